// File: rtl/arb_mux8way16_if.sv
// rtl/arb_mux8way16_if.sv - eight producer channels plus one tagged output stream
interface arb_mux8way16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] h;
    logic [7:0]       in_valid;
    logic [7:0]       in_ready;
    logic [WIDTH-1:0] out;
    logic [2:0]       out_sel;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, c, d, e, f, g, h, in_valid, out_ready,
        input  in_ready, out, out_sel, out_valid
    );

    modport slave (
        input  a, b, c, d, e, f, g, h, in_valid, out_ready,
        output in_ready, out, out_sel, out_valid
    );
endinterface

// File: rtl/arb_mux8way16.sv
// rtl/arb_mux8way16.sv - eight-channel valid/ready merge onto one registered, tagged output
// ARB_MUX8_RR_EN selects round-robin arbitration; undefined gives fixed priority (a highest).
module arb_mux8way16 #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    arb_mux8way16_if.slave  bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       start;
    logic [2:0]       grant;
    logic [2:0]       idx;
    logic             found;
    logic             load;
    logic [WIDTH-1:0] grant_data;

`ifdef ARB_MUX8_RR_EN
    logic [2:0] ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = 3'd0;
`endif

    // Search wraps 7 -> 0 starting at the priority pointer.
    always_comb begin
        grant = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && bus.in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (grant)
            3'd0:    grant_data = bus.a;
            3'd1:    grant_data = bus.b;
            3'd2:    grant_data = bus.c;
            3'd3:    grant_data = bus.d;
            3'd4:    grant_data = bus.e;
            3'd5:    grant_data = bus.f;
            3'd6:    grant_data = bus.g;
            default: grant_data = bus.h;
        endcase
    end

    assign load         = !reset && ((state_q == EMPTY) || bus.out_ready) && (|bus.in_valid);
    assign bus.in_ready = load ? (8'b1 << grant) : 8'b0;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sel_d   = sel_q;
`ifdef ARB_MUX8_RR_EN
        ptr_d   = ptr_q;
`endif
        if (load) begin
            state_d = FULL;
            out_d   = grant_data;
            sel_d   = grant;
`ifdef ARB_MUX8_RR_EN
            ptr_d   = grant + 3'd1;
`endif
        end else if (state_q == FULL && bus.out_ready) begin
            // Drained with nothing to refill: data and tag stay stale.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            out_q   <= '0;
            sel_q   <= 3'd0;
`ifdef ARB_MUX8_RR_EN
            ptr_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sel_q   <= sel_d;
`ifdef ARB_MUX8_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.out       = out_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = (state_q == FULL);
endmodule

// File: tb/tb_arb_mux8way16.sv
// tb/tb_arb_mux8way16.sv - self-checking bench for arb_mux8way16 (honours ARB_MUX8_RR_EN)
module tb_arb_mux8way16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  vin = 8'h00;
    logic        rdy = 1'b0;
    logic [15:0] data [8];
    logic [7:0]  ir;
    int          checks = 0;
    int          errors = 0;

    logic        m_valid = 1'b0;
    logic [15:0] m_out = 16'h0;
    logic [2:0]  m_sel = 3'd0;
    int          m_ptr = 0;

    arb_mux8way16_if #(.WIDTH(16)) bus ();

    assign bus.a = data[0];
    assign bus.b = data[1];
    assign bus.c = data[2];
    assign bus.d = data[3];
    assign bus.e = data[4];
    assign bus.f = data[5];
    assign bus.g = data[6];
    assign bus.h = data[7];
    assign bus.in_valid  = vin;
    assign bus.out_ready = rdy;

    arb_mux8way16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int model_start();
`ifdef ARB_MUX8_RR_EN
        return m_ptr;
`else
        return 0;
`endif
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < 8; k++) begin
            if (vin[(model_start() + k) % 8]) return (model_start() + k) % 8;
        end
        return 0;
    endfunction

    function automatic logic model_load();
        return !reset && (!m_valid || rdy) && (vin != 8'h00);
    endfunction

    function automatic logic [7:0] exp_ready();
        if (!model_load()) return 8'h00;
        return 8'h01 << model_grant();
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_out   <= 16'h0;
            m_sel   <= 3'd0;
            m_ptr   <= 0;
        end else if (model_load()) begin
            m_valid <= 1'b1;
            m_out   <= data[model_grant()];
            m_sel   <= 3'(model_grant());
            m_ptr   <= (model_grant() + 1) % 8;
        end else if (m_valid && rdy) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_in_ready", 32'(bus.in_ready), 32'(exp_ready()));
        chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("cmp_out", 32'(bus.out), 32'(m_out));
        chk("cmp_out_sel", 32'(bus.out_sel), 32'(m_sel));
    end

    task automatic cyc(input logic [7:0] v, input logic r, output logic [7:0] ready);
        vin = v;
        rdy = r;
        #1;
        ready = bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) data[i] = 16'(i);
        reset = 1'b1;
        vin   = 8'hFF;
        rdy   = 1'b1;
        #1;
        chk("reset_in_ready_comb", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'h0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cyc(8'h00, 1'b0, ir);
        chk("idle_out", 32'(bus.out), 32'h0);
        chk("idle_out_sel", 32'(bus.out_sel), 32'h0);
        chk("idle_out_valid", 32'(bus.out_valid), 32'h0);

        data[2] = 16'hBEEF;
        cyc(8'h04, 1'b1, ir);
        chk("single_in_ready", 32'(ir), 32'h04);
        chk("single_out", 32'(bus.out), 32'hBEEF);
        chk("single_out_sel", 32'(bus.out_sel), 32'd2);
        chk("single_out_valid", 32'(bus.out_valid), 32'd1);
        cyc(8'h00, 1'b1, ir);
        chk("single_drained", 32'(bus.out_valid), 32'd0);
        chk("single_stale_out", 32'(bus.out), 32'hBEEF);
        data[2] = 16'h0002;

        reset = 1'b1;
        cyc(8'h00, 1'b1, ir);
        reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cyc(8'hFF, 1'b1, ir);
`ifdef ARB_MUX8_RR_EN
            chk("all_rr_sel", 32'(bus.out_sel), 32'(k % 8));
            chk("all_rr_out", 32'(bus.out), 32'(k % 8));
`else
            chk("all_fp_sel", 32'(bus.out_sel), 32'd0);
`endif
            chk("all_no_bubble", 32'(bus.out_valid), 32'd1);
        end

        cyc(8'h20, 1'b1, ir);
        chk("f_sel", 32'(bus.out_sel), 32'd5);
        for (int k = 0; k < 4; k++) begin
            cyc(8'h81, 1'b0, ir);
            chk("bp_in_ready", 32'(ir), 32'h0);
            chk("bp_out_sel", 32'(bus.out_sel), 32'd5);
            chk("bp_out", 32'(bus.out), 32'd5);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        cyc(8'h81, 1'b1, ir);
`ifdef ARB_MUX8_RR_EN
        chk("wrap_h_ready", 32'(ir), 32'h80);
        chk("wrap_h_sel", 32'(bus.out_sel), 32'd7);
`else
        chk("fp_a_ready", 32'(ir), 32'h01);
        chk("fp_a_sel", 32'(bus.out_sel), 32'd0);
`endif
        cyc(8'h81, 1'b1, ir);
        chk("wrap_a_sel", 32'(bus.out_sel), 32'd0);

        for (int k = 0; k < 3; k++) begin
            cyc(8'h80, 1'b1, ir);
            chk("h_only_sel", 32'(bus.out_sel), 32'd7);
        end
        cyc(8'h03, 1'b1, ir);
        chk("ab_ready", 32'(ir), 32'h01);
        chk("ab_sel", 32'(bus.out_sel), 32'd0);

        cyc(8'h10, 1'b1, ir);
        chk("e_sel", 32'(bus.out_sel), 32'd4);
        chk("e_out", 32'(bus.out), 32'd4);
        reset = 1'b1;
        cyc(8'h18, 1'b1, ir);
        chk("rst_in_ready", 32'(ir), 32'h0);
        reset = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_out_sel", 32'(bus.out_sel), 32'd0);
        cyc(8'h18, 1'b1, ir);
        chk("post_rst_ready", 32'(ir), 32'h08);
        chk("post_rst_sel", 32'(bus.out_sel), 32'd3);
        cyc(8'h00, 1'b1, ir);
        cyc(8'h00, 1'b1, ir);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb_mux8way16.md
# arb_mux8way16

Merges eight 16-bit producer channels onto one registered output stream with valid/ready handshakes. Each beat carries a 3-bit tag naming its source channel, so a downstream `dmux8way16` can route responses back on the same index. The block sits in front of shared resources such as a memory port or I/O bus, where several requesters contend for a single path.

## Interface
- `WIDTH`, default 16: data width of every channel.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `a`..`h` input WIDTH each: data for channels 0..7 (`a`=0 … `h`=7).
- `in_valid` input 8: bit i is set when channel i presents a beat.
- `in_ready` output 8: bit i is set when channel i's beat is accepted this cycle.
- `out` output WIDTH: registered output data.
- `out_sel` output 3: source channel index of the beat on `out`.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: downstream accepts the beat this cycle.

## Operation
- Two states, tracked by `out_valid`:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- `load = (!out_valid | out_ready) & |in_valid`.
- Arbitration is combinational each cycle over `in_valid` and selects exactly one `grant` index g.
- `in_ready[i] = load & (i == g)`. At most one bit is set, and never a bit whose `in_valid` is low.
- On `load`:
  - `out` ← channel g data.
  - `out_sel` ← g.
  - `out_valid` ← 1.
- If `out_valid & out_ready & !|in_valid`: `out_valid` ← 0. `out` and `out_sel` hold their stale values.
- FULL with `out_ready`=0: `out`, `out_sel` and `out_valid` hold, and all `in_ready` bits are 0 (backpressure).
- Simultaneous drain and fill (FULL, `out_ready`=1, any `in_valid`): the new beat replaces the old one in the same edge. No bubble.
- Round-robin pointer `ptr` (3 bits):
  - The search starts at `ptr` and wraps 7→0.
  - After each `load`, `ptr` ← g+1 mod 8. From g=7 it wraps to 0.
  - `ptr` does not change without a `load`.
- Input data and tag are never combinationally visible on `out`.
- Producers must hold `in_valid` and data stable until `in_ready`. The block does not check this.

## Timing
- Reset values:
  - `out_valid`=0, `out`=0, `out_sel`=0, `ptr`=0.
  - `in_ready`=0 during reset regardless of `in_valid`.
- Reset mid-operation: a held beat is discarded, not delivered, and arbitration restarts at channel 0 on the first cycle after reset deasserts.
- Latency: a beat accepted at edge N appears on `out` from edge N onward, one cycle after `in_valid` is presented.
- Throughput: one beat per cycle while `out_ready`=1 and any channel is valid.
- Fairness (RR build): a continuously valid channel is granted within 8 consecutive `load` cycles.
- Combinational paths: `in_valid`/`out_ready` → `in_ready` is combinational. There is no combinational path from inputs to `out`, `out_sel` or `out_valid`.

## Configuration
- `ARB_MUX8_RR_EN`
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, where the lowest valid index wins (`a` highest). `ptr` is removed, or held at 0 with no effect. All handshake, reset and timing rules are unchanged.

## Test plan
- Reset, then `in_valid`=8'h00 → `out_valid`=0, `in_ready`=0, `out`=0, `out_sel`=0 for 10 cycles.
- `out_ready`=1, only `c`=16'hBEEF valid for one cycle → `in_ready`=8'h04 that cycle; next cycle `out`=16'hBEEF, `out_sel`=2, `out_valid`=1; the cycle after, `out_valid`=0.
- All eight channels valid continuously with data 16'h0000 + index, `out_ready`=1 → RR build: `out_sel` sequence 0,1,2,…,7,0 on consecutive cycles with no bubbles. Fixed-priority build: always 0.
- FULL with `out_sel`=5, `out_ready`=0 for 4 cycles while `a` and `h` are valid → `out`/`out_sel` stable and `in_ready`=0 throughout. Raising `out_ready` → `h` granted next (`ptr`=6 wraps via 7), then `a`.
- Only `h` valid, 3 beats → `ptr` wraps to 0. Then `a` and `b` valid → `a` granted first.
- Assert `reset` for one cycle while FULL with `out_sel`=4 → next cycle `out_valid`=0 and `out`=0. With `d` and `e` valid afterwards, `d` is granted first (pointer back at 0).
